// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller. The data-side
// controller is expected to reuse the width, reset vector and state encoding.
//   FETCH_WIDTH     : address / instruction width
//   FETCH_RESET_PC  : first fetch address after reset
//   fetch_state_e   : handshake state encoding (S_REQ, S_WAIT, S_FULL)
// ---------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

    localparam int          FETCH_WIDTH    = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h1c000000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_buf
// One-entry holding register for a fetched instruction and its PC, with a
// valid bit presented to the decode stage.
//   clk, reset        : clock, synchronous active-high reset
//   load              : capture load_pc/load_inst and set valid
//   clear             : drop the held instruction (valid goes low)
//   load_pc, load_inst: values captured on load
//   valid, pc, inst   : registered holding-register contents
// ---------------------------------------------------------------------------
module if_fetch_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_pc,
    input  logic [WIDTH-1:0] load_inst,
    output logic             valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] inst
);

    // pc/inst only move on load, so they stay frozen while decode stalls.
    // Clearing touches only the valid bit; the stale contents are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch controller with at most one outstanding SRAM request.
// Redirects from EX either retarget an unaccepted request, or mark the
// outstanding response for discard, or flush the held instruction.
//   clk, reset          : clock, synchronous active-high reset
//   br_taken, nextpc    : redirect request and target from EX
//   inst_sram_req/addr  : fetch request and address (registered)
//   inst_sram_addr_ok   : request accepted this cycle
//   inst_sram_data_ok   : read data returned this cycle
//   inst_sram_rdata     : returned instruction
//   id_allowin          : decode accepts the held instruction
//   if_valid/pc/inst    : registered instruction presented to decode
// ---------------------------------------------------------------------------
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] nextpc,
    output logic             inst_sram_req,
    output logic [WIDTH-1:0] inst_sram_addr,
    input  logic             inst_sram_addr_ok,
    input  logic             inst_sram_data_ok,
    input  logic [WIDTH-1:0] inst_sram_rdata,
    input  logic             id_allowin,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    fetch_state_e     state;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             cancel;
    logic             buf_load;
    logic             buf_clear;

    assign inst_sram_addr = fetch_pc;

    // A response is kept only when no redirect has hit it, either earlier
    // (cancel) or in the very cycle it arrives (br_taken).
    assign buf_load  = (state == S_WAIT) && inst_sram_data_ok && !cancel && !br_taken;
    assign buf_clear = (state == S_FULL) && (br_taken || id_allowin);

    // Fetch handshake state machine. inst_sram_req is registered and tracks
    // "next state is S_REQ", so it stays low in the first cycle after reset
    // even though the state is already S_REQ; addr_ok is only honoured while
    // the request is actually raised. A redirect that coincides with
    // acceptance lets the old address go out but flags its data for discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_REQ;
            fetch_pc      <= RESET_PC;
            inflight_pc   <= '0;
            cancel        <= 1'b0;
            inst_sram_req <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    inst_sram_req <= 1'b1;
                    if (inst_sram_req && inst_sram_addr_ok) begin
                        inflight_pc   <= fetch_pc;
                        cancel        <= br_taken;
                        state         <= S_WAIT;
                        inst_sram_req <= 1'b0;
                    end
                    if (br_taken) begin
                        fetch_pc <= nextpc;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        cancel        <= 1'b0;
                        state         <= S_REQ;
                        inst_sram_req <= 1'b1;
                        if (br_taken) begin
                            fetch_pc <= nextpc;
                        end else if (!cancel) begin
                            fetch_pc      <= inflight_pc + PC_STEP;
                            state         <= S_FULL;
                            inst_sram_req <= 1'b0;
                        end
                    end else if (br_taken) begin
                        cancel   <= 1'b1;
                        fetch_pc <= nextpc;
                    end
                end
                S_FULL: begin
                    if (br_taken) begin
                        fetch_pc      <= nextpc;
                        state         <= S_REQ;
                        inst_sram_req <= 1'b1;
                    end else if (id_allowin) begin
                        state         <= S_REQ;
                        inst_sram_req <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_REQ;
                    cancel        <= 1'b0;
                    inst_sram_req <= 1'b0;
                end
            endcase
        end
    end

    if_fetch_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (inflight_pc),
        .load_inst (inst_sram_rdata),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Self-checking bench for if_fetch_ctrl. The reference keeps the SRAM side
// as a queue of accepted requests (each tagged live or dead), the address
// the next request must carry, and the instruction held for decode.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        br_taken;
    logic [31:0] nextpc;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_allowin;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks_done;
    int checks_failed;

    logic        m_req;
    logic [31:0] m_next;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [32:0] pend_q[$];

    if_fetch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .br_taken          (br_taken),
        .nextpc            (nextpc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .id_allowin        (id_allowin),
        .if_valid          (if_valid),
        .if_pc             (if_pc),
        .if_inst           (if_inst)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks_done++;
        if (got !== want) begin
            checks_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Compare every DUT output the reference has an opinion on this cycle.
    task automatic checkModel();
        checkOutput("req", 32'(inst_sram_req), 32'(m_req));
        if (m_req) checkOutput("addr", inst_sram_addr, m_next);
        checkOutput("valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("if_pc", if_pc, m_pc);
            checkOutput("if_inst", if_inst, m_inst);
        end
    endtask

    // Advance the reference by one clock given the inputs seen at that edge.
    task automatic updateModel(input logic br, input logic [31:0] npc, input logic aok,
                               input logic dok, input logic [31:0] rd, input logic allow);
        logic [32:0] head;
        if (m_valid) begin
            if (br) begin
                m_valid = 1'b0;
                m_next  = npc;
            end else if (allow) begin
                m_valid = 1'b0;
            end
        end else if (pend_q.size() != 0) begin
            if (dok) begin
                head = pend_q.pop_front();
                if (head[32] && !br) begin
                    m_valid = 1'b1;
                    m_pc    = head[31:0];
                    m_inst  = rd;
                    m_next  = head[31:0] + 32'd4;
                end
            end
            if (br) begin
                foreach (pend_q[i]) pend_q[i][32] = 1'b0;
                m_next = npc;
            end
        end else begin
            if (aok) pend_q.push_back({~br, m_next});
            if (br) m_next = npc;
        end
        m_req = (pend_q.size() == 0) && !m_valid;
    endtask

    // Called at a negedge: drive one cycle of inputs, let the edge happen,
    // advance the reference, then check outputs at the following negedge.
    // Handshakes the SRAM could not legally give are suppressed here.
    task automatic applyStimulus(input logic br, input logic [31:0] npc, input logic aok,
                                 input logic dok, input logic [31:0] rd, input logic allow);
        logic        aok_eff;
        logic        dok_eff;
        logic [31:0] rd_eff;
        aok_eff = aok && m_req;
        dok_eff = dok && (pend_q.size() != 0);
        rd_eff  = dok_eff ? rd : $urandom;
        br_taken          = br;
        nextpc            = npc;
        inst_sram_addr_ok = aok_eff;
        inst_sram_data_ok = dok_eff;
        inst_sram_rdata   = rd_eff;
        id_allowin        = allow;
        @(posedge clk);
        updateModel(br, npc, aok_eff, dok_eff, rd_eff, allow);
        @(negedge clk);
        checkModel();
    endtask

    // Hold reset over a few edges, check the reset values, then release at
    // a negedge with the reference back at its power-on contents.
    task automatic doReset();
        reset             = 1'b1;
        br_taken          = 1'b0;
        nextpc            = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
        id_allowin        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(inst_sram_req), 32'd0);
        checkOutput("rst_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_pc", if_pc, 32'd0);
        checkOutput("rst_inst", if_inst, 32'd0);
        pend_q.delete();
        m_req   = 1'b0;
        m_next  = 32'h1c000000;
        m_valid = 1'b0;
        m_pc    = '0;
        m_inst  = '0;
        reset   = 1'b0;
    endtask

    // Directed scenarios first, then a long randomized run with occasional
    // resets landing in the middle of transactions.
    initial begin
        logic        r_br;
        logic [31:0] r_npc;
        checks_done   = 0;
        checks_failed = 0;

        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("first_req", 32'(inst_sram_req), 32'd1);
        checkOutput("first_addr", inst_sram_addr, 32'h1c000000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h02800c0c, 1'b1);
        checkOutput("d_valid", 32'(if_valid), 32'd1);
        checkOutput("d_pc", if_pc, 32'h1c000000);
        checkOutput("d_inst", if_inst, 32'h02800c0c);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("seq_addr", inst_sram_addr, 32'h1c000004);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("bp_pc", if_pc, 32'h1c000004);
            checkOutput("bp_inst", if_inst, 32'h12345678);
            checkOutput("bp_req", 32'(inst_sram_req), 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h1c000100, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hdeadbeef, 1'b1);
        checkOutput("cancel_valid", 32'(if_valid), 32'd0);
        checkOutput("cancel_addr", inst_sram_addr, 32'h1c000100);

        applyStimulus(1'b1, 32'h1c000008, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("retarget_addr", inst_sram_addr, 32'h1c000008);
        applyStimulus(1'b1, 32'h1c000040, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hbad0bad0, 1'b0);
        checkOutput("same_cyc_valid", 32'(if_valid), 32'd0);
        checkOutput("same_cyc_addr", inst_sram_addr, 32'h1c000040);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00112233, 1'b0);
        checkOutput("after_drop_pc", if_pc, 32'h1c000040);

        applyStimulus(1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("flush_valid", 32'(if_valid), 32'd0);
        checkOutput("flush_addr", inst_sram_addr, 32'h1c000200);

        applyStimulus(1'b1, 32'hfffffffc, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0badf00d, 1'b1);
        checkOutput("wrap_pc", if_pc, 32'hfffffffc);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_addr", inst_sram_addr, 32'h00000000);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h55555555, 1'b1);
        checkOutput("midrst_addr", inst_sram_addr, 32'h1c000000);

        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) doReset();
            r_br  = ($urandom_range(0, 7) == 0);
            r_npc = ($urandom_range(0, 9) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
            applyStimulus(r_br, r_npc, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) < 2),
                          $urandom, ($urandom_range(0, 4) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-002 Parameter WIDTH, default 32, address/instruction width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 br_taken  input  1  redirect request from EX; qualifies nextpc.
REQ-006 nextpc  input  WIDTH  redirect target, sampled only when br_taken=1.
REQ-007 inst_sram_req  output  1  fetch request to instruction SRAM.
REQ-008 inst_sram_addr  output  WIDTH  fetch address, valid while inst_sram_req=1.
REQ-009 inst_sram_addr_ok  input  1  request accepted this cycle (handshake with inst_sram_req).
REQ-010 inst_sram_data_ok  input  1  read data returned this cycle.
REQ-011 inst_sram_rdata  input  WIDTH  instruction, valid when inst_sram_data_ok=1.
REQ-012 id_allowin  input  1  ID accepts an instruction this cycle.
REQ-013 if_valid  output  1  buffered instruction present for ID.
REQ-014 if_pc  output  WIDTH  PC of the buffered instruction.
REQ-015 if_inst  output  WIDTH  buffered instruction.

Function
REQ-016 The block SHALL implement a state machine with states S_REQ, S_WAIT, S_FULL and hold at most one outstanding SRAM request.
REQ-017 S_REQ: inst_sram_req=1, inst_sram_addr=fetch_pc; on addr_ok, latch inflight_pc=fetch_pc and go to S_WAIT.
REQ-018 S_WAIT and S_FULL SHALL drive inst_sram_req=0.
REQ-019 S_WAIT, data_ok with cancel=0: latch if_inst=rdata and if_pc=inflight_pc; set if_valid=1 on the next cycle; set fetch_pc=inflight_pc+4 (modulo 2^32); go to S_FULL.
REQ-020 S_WAIT, data_ok with cancel=1: discard rdata, clear cancel, go to S_REQ; if_valid stays 0.
REQ-021 S_FULL with id_allowin=1: clear if_valid and go to S_REQ, so the next request is raised the following cycle.
REQ-022 br_taken in S_REQ without addr_ok: set fetch_pc=nextpc and stay in S_REQ; changing the address of an unaccepted request is legal.
REQ-023 br_taken in S_REQ with addr_ok in the same cycle: the old address counts as accepted; go to S_WAIT with cancel=1 and fetch_pc=nextpc.
REQ-024 br_taken in S_WAIT without data_ok: set cancel=1 and fetch_pc=nextpc; repeated redirects only overwrite fetch_pc.
REQ-025 br_taken in S_WAIT with data_ok: drop the data, keep cancel=0, set fetch_pc=nextpc, go to S_REQ.
REQ-026 br_taken in S_FULL: clear if_valid, set fetch_pc=nextpc, go to S_REQ; br_taken SHALL take priority over id_allowin.
REQ-027 A cancelled response SHALL never assert if_valid; exactly one data_ok is discarded per cancel.
REQ-028 if_valid, if_pc and if_inst SHALL be registered; latency from data_ok to if_valid is 1 cycle.
REQ-029 if_pc and if_inst SHALL remain stable while if_valid=1 and id_allowin=0.

Reset
REQ-030 During reset: state=S_REQ, fetch_pc=RESET_PC, cancel=0, if_valid=0, if_pc=0, if_inst=0, inst_sram_req=0.
REQ-031 inst_sram_req SHALL first assert in the cycle after reset deasserts, with addr=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; the SRAM side is reset together with this block.

Structure
REQ-033 A shared package SHALL hold WIDTH, RESET_PC and the state encoding (S_REQ, S_WAIT, S_FULL), for reuse by a later data-side controller.
REQ-034 The block is flat; one optional sub-module, if_fetch_buf (the pc/inst holding register with a valid bit), is natural.

Verification
REQ-035 Reset, then addr_ok=1 in the first request cycle and data_ok 2 cycles later with rdata=32'h02800c0c, id_allowin=1 -> addr=1c000000; if_valid=1 with if_pc=1c000000 and if_inst=02800c0c; next request addr=1c000004.
REQ-036 Back-pressure: id_allowin=0 for 5 cycles in S_FULL -> if_valid, if_pc and if_inst stable and inst_sram_req=0 throughout.
REQ-037 br_taken (nextpc=1c000100) in S_WAIT, data_ok 3 cycles later -> data discarded, if_valid never set, next request addr=1c000100.
REQ-038 br_taken and addr_ok in the same cycle at pc=1c000008, nextpc=1c000040 -> first data_ok dropped; next request at 1c000040.
REQ-039 br_taken and id_allowin in the same cycle in S_FULL -> if_valid=0 next cycle; request at nextpc.
REQ-040 fetch_pc=ffffffff8... i.e. inflight_pc=32'hfffffffc completes -> next request addr=32'h00000000 (wrap-around).
